// File: rtl/div_unit.sv
// div_unit -- multi-cycle 32-bit integer divider for the EX stage.
//
// Restoring shift-subtract divider, one quotient bit per clock. EX raises
// start_i with the operands and holds it until it has consumed ready_o; the
// block then returns {remainder, quotient} on result_o.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, held high until ready_o is consumed
//   annul_i       pipeline-flush abort (only honoured with DIV_ANNUL_EN)
//   result_o      {remainder[31:0], quotient[31:0]}, registered
//   ready_o       result valid, registered
//
// Build option: define DIV_ANNUL_EN to let annul_i abort a division in
// progress and block a start in IDLE. Without it annul_i is unused.

module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;       // {partial remainder (33b), dividend/quotient (32b)}
  logic [31:0] divisor_q, divisor_d; // divisor magnitude
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        abort;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

`ifdef DIV_ANNUL_EN
  assign abort = annul_i;
`else
  assign abort = 1'b0;
  logic unused_annul;
  assign unused_annul = annul_i;
`endif

  // The partial remainder always stays below the divisor after an iteration,
  // so the top bit of the working register is zero on entry to each shift.
  logic unused_work_msb;
  assign unused_work_msb = work_q[64];

  // Two's-complement magnitudes; 0x80000000 maps to unsigned 2^31.
  assign dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign shifted = {work_q[63:0], 1'b0};
  assign diff    = shifted[64:32] - {1'b0, divisor_q};

  assign quot_fix = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix  = neg_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      ST_IDLE: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
        if (start_i && !abort) begin
          if (opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d    = ST_ON;
            cnt_d      = 6'd0;
            work_d     = {33'd0, dividend_abs};
            divisor_d  = divisor_abs;
            neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d  = signed_div_i && opdata1_i[31];
          end
        end
      end

      ST_BYZERO: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_END;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end

      ST_ON: begin
        if (abort) begin
          // Abort wins even on the completion edge, so ready_o never rises.
          state_d  = ST_IDLE;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (shifted[64:32] >= {1'b0, divisor_q}) begin
            work_d = {diff, shifted[31:1], 1'b1};
          end else begin
            work_d = shifted;
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = ST_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end

      ST_END: begin
        if (!start_i) begin
          state_d  = ST_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a table of directed divisions plus
// hand-written sequences for annul, annul-on-completion and mid-run reset.

module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests_run;
  int tests_failed;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Issue one division, measure edges to ready, check hold and release.
  task automatic do_op(input string name, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int   edges;
    logic got;
    logic [63:0] res;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges = 0;
    got   = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) got = 1'b1;
    end
    if (!got) edges = -1;
    res = result_o;
    chk({name, " latency"}, 64'(edges), 64'(exp_lat));
    chk({name, " result"}, res, exp_res);
    // Operand changes after latch must not disturb the held result.
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, " held ready"}, 64'(ready_o), 64'd1);
    chk({name, " held result"}, result_o, exp_res);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " release ready"}, 64'(ready_o), 64'd0);
    chk({name, " release result"}, result_o, 64'd0);
  endtask

  // Count ready_o highs over n edges (start_i is expected low).
  task automatic quiet_for(input string name, input int n);
    int highs;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) highs++;
    end
    chk(name, 64'(highs), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         34};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  34};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001,  32'hFFFF_FFFD},  34};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000,  32'h8000_0000},  34};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'h0000_0000},  34};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'd0,                            2};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'd14},         34};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF},  34};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'd3,          32'd0},          34};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0,                            2};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,          32'd1},          34};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      do_op($sformatf("vec%0d", v), vecs[v].s, vecs[v].a, vecs[v].b,
            vecs[v].exp_res, vecs[v].exp_lat);
    end

    // Annul pulse sampled while cnt=10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);   // E0..E10
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);               // E11
    #1;
    chk("annul edge ready", 64'(ready_o), 64'd0);
`ifdef DIV_ANNUL_EN
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    quiet_for("annul no ready", 40);
    do_op("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Annul held in IDLE blocks the start.
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    begin
      int highs;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (ready_o) highs++;
      end
      chk("annul blocks start", 64'(highs), 64'd0);
    end
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk);

    // Annul on the completion edge wins.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (33) @(posedge clk);   // E0..E32, cnt=32
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);               // E33
    #1;
    chk("annul at completion ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    quiet_for("annul at completion quiet", 40);
`else
    @(negedge clk);
    annul_i = 1'b0;
    begin
      int   edges;
      logic got;
      edges = 12;
      got   = ready_o;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk);
        #1;
        edges++;
        if (ready_o) got = 1'b1;
      end
      if (!got) edges = -1;
      chk("annul ignored latency", 64'(edges), 64'd34);
      chk("annul ignored result", result_o, {32'd2, 32'd14});
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul ignored release", 64'(ready_o), 64'd0);
`endif

    // Reset at cnt=20.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);   // E0..E20
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset ready", 64'(ready_o), 64'd0);
    chk("mid reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_for("after reset quiet", 40);
    do_op("after reset 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
